egress_cpl_rdresp: RTL and testbench
====================================

Name: egress_cpl_rdresp

Overview:
- Completer side for register reads: answers each MRd TLP decoded at ingress with one 1-DW CplD TLP on the egress stream.
- Captures per-request completion fields when the ingress read-request decoder issues rd_req, and queues them in arrival order.
- Pairs each queued entry with the 32-bit register value returned by the action modules, then serialises header and data into two 64-bit beats.

Parameters:
PEND_DEPTH, 4, outstanding-request queue depth (power of 2, >=2)
DATA_WIDTH, 64, egress stream width; block supports 64 only
KEEP_WIDTH, 8, byte-enable width (DATA_WIDTH/8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
completer_id  in  16  {bus,dev,func} of this endpoint, quasi-static
rd_req  in  1  one-cycle pulse: a read request was decoded
rd_tdest  in  10  {register,action,channel} of that request
rd_req_id  in  16  requester ID from the MRd header, valid with rd_req
rd_tag  in  8  tag from the MRd header, valid with rd_req
rd_tc  in  3  traffic class, valid with rd_req
rd_attr  in  2  attributes, valid with rd_req
rd_laddr  in  7  address[6:0], valid with rd_req
pend_full  out  1  queue full; upstream must not pulse rd_req
rd_dat  in  32  register read value from an action module
rd_dat_valid  in  1  rd_dat valid
rd_dat_rdy  out  1  accept rd_dat
cpl_data  out  64  egress TLP beat
cpl_keep  out  8  byte enables
cpl_last  out  1  last beat of TLP
cpl_valid  out  1  beat valid
cpl_rdy  in  1  egress ready
err_ovf  out  1  sticky: rd_req arrived while queue full
err_orphan  out  1  one-cycle pulse: rd_dat arrived with queue empty

Behaviour:
- Reset: all outputs 0, queue empty, FSM=IDLE, sticky flags cleared. Reset is asynchronous; a TLP in flight is abandoned, with no partial beat after deassert.
- Enqueue: on rd_req, write {tdest,req_id,tag,tc,attr,laddr} if not full. If full: drop the entry and set err_ovf; queue contents are unchanged.
- pend_full = (count==PEND_DEPTH), registered.
- Read responses arrive in request order. tdest is stored for debug/trace only.
- rd_dat_rdy = (state==IDLE) && queue non-empty.
- Orphan response: rd_dat_valid while the queue is empty is accepted (dropped) and pulses err_orphan.
- FSM IDLE:
  - On rd_dat_valid && rd_dat_rdy, latch rd_dat and the queue head, pop the head, go to HDR.
  - Same-cycle enqueue and pop are both honoured; count is unchanged.
- FSM HDR: cpl_valid=1, cpl_keep=8'hFF, cpl_last=0. cpl_data[31:0]=DW0, [63:32]=DW1. Advance to DATA on cpl_rdy.
- FSM DATA: cpl_valid=1, cpl_keep=8'hFF, cpl_last=1. cpl_data[31:0]=DW2, [63:32]=rd_dat latched. Go to IDLE on cpl_rdy.
- Header fields:
  - DW0: fmt=3'b010, type=5'b01010, TC=tc, attr=attr, TD=EP=0, AT=0, length=10'd1.
  - DW1: completer_id, status=3'b000, BCM=0, byte_count=12'd4.
  - DW2: requester_id=req_id, tag, R=0, lower_addr=laddr.
- cpl_data/keep/last are stable while cpl_valid && !cpl_rdy.
- Outputs registered; latency from rd_dat accept to first beat = 1 cycle. Back-to-back TLPs have 1 IDLE cycle between them. Throughput is 1 TLP per 3 cycles at cpl_rdy=1.
- Queue pointers wrap modulo PEND_DEPTH. Count width is clog2(PEND_DEPTH)+1.

Test Plan:
- Single read: rd_req (req_id=16'h0100, tag=8'h05, laddr=7'h24, tc=0, attr=0), then rd_dat=32'hDEADBEEF, cpl_rdy=1, completer_id=16'h0200. Required beat0 DW0=32'h4A000001, DW1=32'h02000004. Required beat1 DW2=32'h01000524, data=32'hDEADBEEF, last=1.
- Backpressure: hold cpl_rdy=0 for 5 cycles in HDR and 3 in DATA -> beats held stable, no duplicate beats, rd_dat_rdy=0 throughout.
- Ordering: 4 rd_req with tags 1..4, then 4 responses A..D -> four TLPs with tag/data pairs (1,A),(2,B),(3,C),(4,D); pend_full high after the 4th request, low after the first pop.
- Overflow: 5 rd_req with no responses -> err_ovf=1, 5th dropped; 4 responses give tags 1..4 only.
- Orphan: rd_dat_valid with empty queue -> accepted, err_orphan pulses once, no TLP emitted.
- Reset mid-TLP: assert rst_n=0 during DATA -> cpl_valid=0 immediately, queue empty, err flags 0 after release.

Source files
------------

// File: rtl/egress_cpl_rdresp.sv
// Register-read completer: queues decoded MRd requests and answers each with a
// 1-DW CplD TLP (header beat, then DW2 + data beat) on a 64-bit egress stream.
module egress_cpl_rdresp #(
    parameter int unsigned PEND_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           completer_id,
    input  logic                  rd_req,
    input  logic [9:0]            rd_tdest,
    input  logic [15:0]           rd_req_id,
    input  logic [7:0]            rd_tag,
    input  logic [2:0]            rd_tc,
    input  logic [1:0]            rd_attr,
    input  logic [6:0]            rd_laddr,
    output logic                  pend_full,
    input  logic [31:0]           rd_dat,
    input  logic                  rd_dat_valid,
    output logic                  rd_dat_rdy,
    output logic [DATA_WIDTH-1:0] cpl_data,
    output logic [KEEP_WIDTH-1:0] cpl_keep,
    output logic                  cpl_last,
    output logic                  cpl_valid,
    input  logic                  cpl_rdy,
    output logic                  err_ovf,
    output logic                  err_orphan
);

    localparam int unsigned PTR_W = $clog2(PEND_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [9:0]  tdest;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  laddr;
    } pend_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    pend_t                  pend_q [PEND_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    state_t                 state;
    state_t                 state_nxt;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic                   rdy_nxt;
    logic                   orphan_nxt;
    logic [15:0]            cur_req_id;
    logic [7:0]             cur_tag;
    logic [6:0]             cur_laddr;
    logic [31:0]            cur_dat;
    logic [31:0]            dw0_head;
    logic [31:0]            dw1;
    logic [31:0]            dw2_cur;
    logic [DATA_WIDTH-1:0]  data_nxt;
    logic [KEEP_WIDTH-1:0]  keep_nxt;
    logic                   valid_nxt;
    logic                   last_nxt;

    // Queue bookkeeping; a request seen while full is dropped.
    always_comb begin
        push       = rd_req && (count != CNT_W'(PEND_DEPTH));
        accept     = rd_dat_valid && rd_dat_rdy;
        orphan_nxt = rd_dat_valid && (count == '0);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        rdy_nxt    = (state_nxt == IDLE) && (count_nxt != '0);
    end

    // Header dwords: DW0/DW1 come from the queue head at accept, DW2 from the latched entry.
    always_comb begin
        dw0_head = {3'b010, 5'b01010, 1'b0, pend_q[rd_ptr].tc, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, pend_q[rd_ptr].attr, 2'b00, 10'd1};
        dw1      = {completer_id, 3'b000, 1'b0, 12'd4};
        dw2_cur  = {cur_req_id, cur_tag, 1'b0, cur_laddr};
    end

    // Next-state and next-output logic; beats hold while the sink stalls.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        valid_nxt = cpl_valid;
        last_nxt  = cpl_last;
        data_nxt  = cpl_data;
        keep_nxt  = cpl_keep;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HDR;
                    pop       = 1'b1;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    keep_nxt  = '1;
                    data_nxt  = DATA_WIDTH'({dw1, dw0_head});
                end
            end
            HDR: begin
                if (cpl_rdy) begin
                    state_nxt = DATA;
                    last_nxt  = 1'b1;
                    data_nxt  = DATA_WIDTH'({cur_dat, dw2_cur});
                end
            end
            DATA: begin
                if (cpl_rdy) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    keep_nxt  = '0;
                    data_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                keep_nxt  = '0;
                data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pend_q[wr_ptr] <= '{tdest: rd_tdest, req_id: rd_req_id, tag: rd_tag,
                                tc: rd_tc, attr: rd_attr, laddr: rd_laddr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_full  <= 1'b0;
            rd_dat_rdy <= 1'b0;
            err_ovf    <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_nxt;
            pend_full  <= (count_nxt == CNT_W'(PEND_DEPTH));
            rd_dat_rdy <= rdy_nxt;
            err_ovf    <= err_ovf | (rd_req && !push);
            err_orphan <= orphan_nxt;
        end
    end

    // Per-TLP context captured at the read-data handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_req_id <= '0;
            cur_tag    <= '0;
            cur_laddr  <= '0;
            cur_dat    <= '0;
        end else if (pop) begin
            cur_req_id <= pend_q[rd_ptr].req_id;
            cur_tag    <= pend_q[rd_ptr].tag;
            cur_laddr  <= pend_q[rd_ptr].laddr;
            cur_dat    <= rd_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_valid <= 1'b0;
            cpl_last  <= 1'b0;
            cpl_keep  <= '0;
            cpl_data  <= '0;
        end else begin
            cpl_valid <= valid_nxt;
            cpl_last  <= last_nxt;
            cpl_keep  <= keep_nxt;
            cpl_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_egress_cpl_rdresp.sv
// Self-checking bench for egress_cpl_rdresp: directed scenarios plus randomized
// request/response traffic checked against a queue-based completion model.
module tb_egress_cpl_rdresp;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] completer_id;
    logic        rd_req;
    logic [9:0]  rd_tdest;
    logic [15:0] rd_req_id;
    logic [7:0]  rd_tag;
    logic [2:0]  rd_tc;
    logic [1:0]  rd_attr;
    logic [6:0]  rd_laddr;
    logic        pend_full;
    logic [31:0] rd_dat;
    logic        rd_dat_valid;
    logic        rd_dat_rdy;
    logic [63:0] cpl_data;
    logic [7:0]  cpl_keep;
    logic        cpl_last;
    logic        cpl_valid;
    logic        cpl_rdy;
    logic        err_ovf;
    logic        err_orphan;

    egress_cpl_rdresp #(.PEND_DEPTH(DEPTH), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .completer_id(completer_id),
        .rd_req(rd_req), .rd_tdest(rd_tdest), .rd_req_id(rd_req_id), .rd_tag(rd_tag),
        .rd_tc(rd_tc), .rd_attr(rd_attr), .rd_laddr(rd_laddr), .pend_full(pend_full),
        .rd_dat(rd_dat), .rd_dat_valid(rd_dat_valid), .rd_dat_rdy(rd_dat_rdy),
        .cpl_data(cpl_data), .cpl_keep(cpl_keep), .cpl_last(cpl_last),
        .cpl_valid(cpl_valid), .cpl_rdy(cpl_rdy), .err_ovf(err_ovf), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  laddr;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    int   n_chk, n_fail;
    int   beats_seen, beats_exp;

    always @(posedge clk) begin
        if (rst_n && cpl_valid && cpl_rdy) beats_seen++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input ent_t e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic rand_ent(output ent_t e);
        e.rid   = 16'($urandom);
        e.tag   = 8'($urandom);
        e.tc    = 3'($urandom);
        e.attr  = 2'($urandom);
        e.laddr = 7'($urandom);
    endtask

    task automatic drive_req(input ent_t e);
        rd_req    = 1'b1;
        rd_req_id = e.rid;
        rd_tag    = e.tag;
        rd_tc     = e.tc;
        rd_attr   = e.attr;
        rd_laddr  = e.laddr;
        rd_tdest  = 10'($urandom);
    endtask

    // Issue one read request while the completer is idle.
    task automatic do_req(input ent_t e);
        drive_req(e);
        step();
        rd_req = 1'b0;
        push_model(e);
        chk("pend_full", pend_full, mq.size() == DEPTH);
        chk("err_ovf", err_ovf, m_ovf);
        chk("rdy_after_req", rd_dat_rdy, 1);
    endtask

    // Return one read value and collect its TLP with the given stall lengths.
    task automatic do_resp(input logic [31:0] d, input int hs, input int ds, input bit with_req);
        ent_t e, nr;
        logic [31:0] dw0, dw1, dw2;
        int n = 0;
        while (rd_dat_rdy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rdy_wait", rd_dat_rdy, 1);
        if (rd_dat_rdy !== 1'b1) return;
        rd_dat       = d;
        rd_dat_valid = 1'b1;
        cpl_rdy      = 1'b0;
        if (with_req) begin
            rand_ent(nr);
            drive_req(nr);
            push_model(nr);
        end
        e = mq.pop_front();
        step();
        rd_dat_valid = 1'b0;
        rd_req       = 1'b0;
        rd_dat       = $urandom;
        dw0 = 32'h4A00_0001 | (32'(e.tc) << 20) | (32'(e.attr) << 12);
        dw1 = {completer_id, 16'h0004};
        dw2 = {e.rid, e.tag, 1'b0, e.laddr};
        chk("pend_full_pop", pend_full, mq.size() == DEPTH);
        chk("err_ovf_pop", err_ovf, m_ovf);
        for (int i = 0; i <= hs; i++) begin
            chk("hdr_valid", cpl_valid, 1);
            chk("hdr_data", cpl_data, {dw1, dw0});
            chk("hdr_keep", cpl_keep, 8'hFF);
            chk("hdr_last", cpl_last, 0);
            chk("hdr_rdy_blocked", rd_dat_rdy, 0);
            cpl_rdy = (i == hs);
            step();
        end
        cpl_rdy = 1'b0;
        for (int i = 0; i <= ds; i++) begin
            chk("data_valid", cpl_valid, 1);
            chk("data_data", cpl_data, {d, dw2});
            chk("data_keep", cpl_keep, 8'hFF);
            chk("data_last", cpl_last, 1);
            chk("data_rdy_blocked", rd_dat_rdy, 0);
            cpl_rdy = (i == ds);
            step();
        end
        cpl_rdy = 1'b0;
        beats_exp += 2;
        chk("idle_valid", cpl_valid, 0);
        chk("idle_rdy", rd_dat_rdy, mq.size() != 0);
    endtask

    task automatic do_orphan();
        rd_dat       = $urandom;
        rd_dat_valid = 1'b1;
        step();
        rd_dat_valid = 1'b0;
        chk("orphan_pulse", err_orphan, 1);
        chk("orphan_no_tlp", cpl_valid, 0);
        step();
        chk("orphan_clear", err_orphan, 0);
        chk("orphan_no_tlp2", cpl_valid, 0);
    endtask

    initial begin
        ent_t e;
        int   nreq;
        rst_n = 1'b0; completer_id = 16'h0200; rd_req = 1'b0; rd_tdest = '0;
        rd_req_id = '0; rd_tag = '0; rd_tc = '0; rd_attr = '0; rd_laddr = '0;
        rd_dat = '0; rd_dat_valid = 1'b0; cpl_rdy = 1'b0;
        n_chk = 0; n_fail = 0; beats_seen = 0; beats_exp = 0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", cpl_valid, 0);
        chk("rst_data", cpl_data, 0);
        chk("rst_keep", cpl_keep, 0);
        chk("rst_last", cpl_last, 0);
        chk("rst_full", pend_full, 0);
        chk("rst_rdy", rd_dat_rdy, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_orphan", err_orphan, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single read with the reference values.
        e = '{16'h0100, 8'h05, 3'd0, 2'd0, 7'h24};
        do_req(e);
        do_resp(32'hDEADBEEF, 0, 0, 1'b0);
        chk("single_beats", beats_seen, beats_exp);

        // Backpressure in both beats.
        rand_ent(e);
        do_req(e);
        do_resp(32'h1234_5678, 5, 3, 1'b0);
        chk("bp_beats", beats_seen, beats_exp);

        // Ordering with the queue exactly full.
        for (int i = 1; i <= 4; i++) begin
            rand_ent(e);
            e.tag = 8'(i);
            do_req(e);
        end
        do_resp(32'hAAAA_AAAA, 0, 0, 1'b0);
        do_resp(32'hBBBB_BBBB, 0, 0, 1'b0);
        do_resp(32'hCCCC_CCCC, 0, 0, 1'b0);
        do_resp(32'hDDDD_DDDD, 0, 0, 1'b0);

        // Overflow: fifth request dropped.
        for (int i = 1; i <= 5; i++) begin
            rand_ent(e);
            e.tag = 8'(i);
            do_req(e);
        end
        chk("ovf_sticky", err_ovf, 1);
        while (mq.size() > 0) do_resp($urandom, 0, 0, 1'b0);

        // Orphan response.
        do_orphan();

        // Randomized traffic, occasionally with a request on the pop cycle.
        for (int it = 0; it < 20; it++) begin
            completer_id = 16'($urandom);
            nreq = $urandom_range(1, 5);
            for (int k = 0; k < nreq; k++) begin
                rand_ent(e);
                do_req(e);
            end
            while (mq.size() > 0)
                do_resp($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) do_orphan();
        end
        chk("rand_beats", beats_seen, beats_exp);

        // Reset during the data beat.
        for (int i = 0; i < 5; i++) begin
            rand_ent(e);
            do_req(e);
        end
        rd_dat = 32'hCAFE_F00D;
        rd_dat_valid = 1'b1;
        step();
        rd_dat_valid = 1'b0;
        chk("mid_hdr_valid", cpl_valid, 1);
        cpl_rdy = 1'b1;
        step();
        cpl_rdy = 1'b0;
        beats_exp += 1;
        chk("mid_data_last", cpl_last, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", cpl_valid, 0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", cpl_valid, 0);
        chk("post_rst_ovf", err_ovf, 0);
        chk("post_rst_orphan", err_orphan, 0);
        chk("post_rst_full", pend_full, 0);
        chk("post_rst_rdy", rd_dat_rdy, 0);
        do_orphan();
        rand_ent(e);
        do_req(e);
        do_resp($urandom, 1, 1, 1'b0);
        chk("final_beats", beats_seen, beats_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
